// File: rtl/gshare_pattern_table_if.sv
// gshare_pattern_table_if: lookup, prediction and resolved-branch update signals of the gshare PHT.
interface gshare_pattern_table_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 7,
    parameter int GHR_WIDTH   = 7
);
    logic                   lookup_valid;
    logic [ADDR_WIDTH-1:0]  lookup_address;
    logic [GHR_WIDTH-1:0]   global_history;
    logic                   lookup_ready;
    logic                   pred_valid;
    logic                   pred_taken;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic                   update_valid;
    logic [INDEX_WIDTH-1:0] update_index;
    logic                   update_taken;
    logic                   update_mispredict;
    modport master (
        output lookup_valid, lookup_address, global_history,
        output update_valid, update_index, update_taken, update_mispredict,
        input  lookup_ready, pred_valid, pred_taken, pred_index
    );
    modport slave (
        input  lookup_valid, lookup_address, global_history,
        input  update_valid, update_index, update_taken, update_mispredict,
        output lookup_ready, pred_valid, pred_taken, pred_index
    );
endinterface

// File: rtl/gshare_pattern_table.sv
// gshare_pattern_table: 2-bit saturating-counter PHT indexed by address XOR global history.
// Optional GSHARE_PATTERN_TABLE_STATS_EN adds update/mispredict counters.
module gshare_pattern_table #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 7,
    parameter int GHR_WIDTH   = 7
) (
    input  logic clk,
    input  logic async_rst,
    input  logic clk_en,
    gshare_pattern_table_if.slave bus
`ifdef GSHARE_PATTERN_TABLE_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;
    logic [INDEX_WIDTH-1:0] ptr, idx;
    logic [1:0] pht [0:(1<<INDEX_WIDTH)-1];
    logic [1:0] upd_cur, upd_nxt, lkp_ctr;
    logic ready, lkp_go, upd_go;
    logic unused_bits;

    always_ff @(posedge clk or posedge async_rst)
        if (async_rst) state <= INIT;
        else if (clk_en) state <= state_nxt;

    always_comb state_nxt = (state == INIT && ptr == '1) ? RUN : state;

    always_comb ready = state == RUN;

    always_ff @(posedge clk or posedge async_rst)
        if (async_rst) ptr <= '0;
        else if (clk_en && state == INIT) ptr <= ptr + 1'b1;

    assign bus.lookup_ready = ready;
    assign lkp_go = ready & bus.lookup_valid;
    assign upd_go = ready & bus.update_valid;
    assign idx = bus.lookup_address[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(bus.global_history);
    assign upd_cur = pht[bus.update_index];
    assign upd_nxt = bus.update_taken ? (upd_cur == 2'b11 ? upd_cur : upd_cur + 2'd1)
                                      : (upd_cur == 2'b00 ? upd_cur : upd_cur - 2'd1);
    // write-first: a same-cycle update to the looked-up entry is visible to the lookup
    assign lkp_ctr = (upd_go && bus.update_index == idx) ? upd_nxt : pht[idx];
    assign unused_bits = ^{bus.lookup_address, bus.update_mispredict};

    always_ff @(posedge clk)
        if (clk_en) begin
            if (state == INIT) pht[ptr] <= 2'b01;
            else if (bus.update_valid) pht[bus.update_index] <= upd_nxt;
        end

    always_ff @(posedge clk or posedge async_rst)
        if (async_rst) begin
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_index <= '0;
        end else if (clk_en) begin
            bus.pred_valid <= lkp_go;
            if (lkp_go) begin
                bus.pred_taken <= lkp_ctr[1];
                bus.pred_index <= idx;
            end
        end

`ifdef GSHARE_PATTERN_TABLE_STATS_EN
    always_ff @(posedge clk or posedge async_rst)
        if (async_rst) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (clk_en && upd_go) begin
            stat_updates     <= stat_updates + 32'd1;
            stat_mispredicts <= stat_mispredicts + {31'd0, bus.update_mispredict};
        end
`endif
endmodule
